// File: rtl/pb_imem_loader_if.sv
// rtl/pb_imem_loader_if.sv - load-port bundle between the byte stream source and the imem loader
interface pb_imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              w_en;
  logic              busy;
  logic              done;
  logic              proc_hold;
  logic [31:0]       checksum;

  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, load_addr, load_data, w_en, busy, done, proc_hold, checksum
  );

  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, load_addr, load_data, w_en, busy, done, proc_hold, checksum
  );
endinterface

// File: rtl/pb_imem_loader.sv
// rtl/pb_imem_loader.sv - packs a byte stream little-endian into words and writes them to imem
module pb_imem_loader #(
  parameter int MEM_DEPTH = 64
) (
  input logic             test_clk,
  input logic             rst,
  pb_imem_loader_if.slave lif
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       partial;
  logic [1:0]        byte_idx;

  logic              byte_take;
  logic [ADDR_W:0]   start_count;
  logic              last_word;

  assign lif.byte_ready = (state == S_COLLECT);
  assign byte_take      = lif.byte_valid && lif.byte_ready;

  // Clamping the count is what keeps addr from ever wrapping past MEM_DEPTH-1.
  assign start_count = (lif.num_words > DEPTH_CNT) ? DEPTH_CNT : lif.num_words;
  assign last_word   = (({1'b0, addr} + ONE_CNT) == count);

  always_ff @(posedge test_clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      count         <= '0;
      addr          <= '0;
      partial       <= '0;
      byte_idx      <= '0;
      lif.load_addr <= '0;
      lif.load_data <= '0;
      lif.w_en      <= 1'b0;
      lif.busy      <= 1'b0;
      lif.done      <= 1'b0;
      lif.proc_hold <= 1'b1;
      lif.checksum  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lif.start) begin
            count        <= start_count;
            addr         <= '0;
            byte_idx     <= '0;
            lif.checksum <= '0;
            if (start_count == '0) begin
              lif.done      <= 1'b1;
              lif.proc_hold <= 1'b0;
            end else begin
              lif.done      <= 1'b0;
              lif.proc_hold <= 1'b1;
              lif.busy      <= 1'b1;
              state         <= S_COLLECT;
            end
          end
        end

        S_COLLECT: begin
          if (byte_take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: partial[7:0]   <= lif.byte_data;
              2'd1: partial[15:8]  <= lif.byte_data;
              2'd2: partial[23:16] <= lif.byte_data;
              default: begin
                lif.load_addr <= addr;
                lif.load_data <= {lif.byte_data, partial};
                lif.w_en      <= 1'b1;
                state         <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          lif.w_en     <= 1'b0;
          lif.checksum <= lif.checksum ^ lif.load_data;
          if (last_word) begin
            lif.busy      <= 1'b0;
            lif.done      <= 1'b1;
            lif.proc_hold <= 1'b0;
            state         <= S_IDLE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_COLLECT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pb_imem_loader.sv
// tb/tb_pb_imem_loader.sv - directed bench with a word-level reference model of the imem loader
module tb_pb_imem_loader;
  logic test_clk = 1'b0;
  logic rst      = 1'b0;

  int checks = 0;
  int errors = 0;

  pb_imem_loader_if #(.ADDR_W(6)) lif ();

  pb_imem_loader #(.MEM_DEPTH(64)) dut (
    .test_clk (test_clk),
    .rst      (rst),
    .lif      (lif.slave)
  );

  always #5 test_clk = ~test_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a load is "count words, each built from 4 bytes in arrival order".
  logic        m_ready = 1'b0, m_wen = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_hold = 1'b1;
  logic [5:0]  m_addr  = '0;
  logic [31:0] m_data  = '0, m_cks = '0;
  int          m_count = 0, m_written = 0;
  logic [7:0]  m_bytes[$];

  always @(posedge test_clk or posedge rst) begin
    if (rst) begin
      m_ready = 0; m_wen = 0; m_busy = 0; m_done = 0; m_hold = 1;
      m_addr = '0; m_data = '0; m_cks = '0; m_count = 0; m_written = 0;
      m_bytes.delete();
    end else if (m_wen) begin
      m_cks = m_cks ^ m_data;
      m_wen = 0;
      m_written++;
      if (m_written == m_count) begin
        m_busy = 0; m_done = 1; m_hold = 0;
      end else begin
        m_ready = 1;
      end
    end else if (!m_busy) begin
      if (lif.start) begin
        m_count   = (lif.num_words > 7'd64) ? 64 : int'(lif.num_words);
        m_written = 0;
        m_cks     = '0;
        m_bytes.delete();
        if (m_count == 0) begin
          m_done = 1; m_hold = 0;
        end else begin
          m_done = 0; m_hold = 1; m_busy = 1; m_ready = 1;
        end
      end
    end else if (lif.byte_valid) begin
      m_bytes.push_back(lif.byte_data);
      if (m_bytes.size() == 4) begin
        m_data  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_addr  = m_written[5:0];
        m_wen   = 1;
        m_ready = 0;
        m_bytes.delete();
      end
    end
  end

  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge test_clk) begin
    chk("byte_ready", 32'(lif.byte_ready), 32'(m_ready));
    chk("w_en",       32'(lif.w_en),       32'(m_wen));
    chk("busy",       32'(lif.busy),       32'(m_busy));
    chk("done",       32'(lif.done),       32'(m_done));
    chk("proc_hold",  32'(lif.proc_hold),  32'(m_hold));
    chk("checksum",   lif.checksum,        m_cks);
    if (m_wen) begin
      chk("load_addr", 32'(lif.load_addr), 32'(m_addr));
      chk("load_data", lif.load_data,      m_data);
    end
    if (lif.w_en === 1'b1) begin
      log_addr.push_back(lif.load_addr);
      log_data.push_back(lif.load_data);
    end
  end

  task automatic do_start(input int n);
    lif.start     = 1'b1;
    lif.num_words = 7'(n);
    @(posedge test_clk); #1;
    lif.start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      lif.byte_valid = 1'b0;
      @(posedge test_clk); #1;
    end
    lif.byte_valid = 1'b1;
    lif.byte_data  = b;
    t = 0;
    while (!lif.byte_ready && t < 100) begin
      @(posedge test_clk); #1;
      t++;
    end
    if (t >= 100) chk("byte_accept_timeout", 32'(t), 32'd0);
    @(posedge test_clk); #1;
    lif.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((lif.busy || !lif.done) && t < 2000) begin
      @(posedge test_clk); #1;
      t++;
    end
    if (t >= 2000) chk(name, 32'(t), 32'd0);
    @(posedge test_clk); #1;
  endtask

  initial begin
    lif.start = 0; lif.num_words = '0; lif.byte_valid = 0; lif.byte_data = '0;

    // 1: reset
    rst = 1'b1;
    repeat (3) @(posedge test_clk);
    #1;
    chk("rst_w_en", 32'(lif.w_en), 32'd0);
    chk("rst_byte_ready", 32'(lif.byte_ready), 32'd0);
    chk("rst_proc_hold", 32'(lif.proc_hold), 32'd1);
    chk("rst_done", 32'(lif.done), 32'd0);
    chk("rst_checksum", lif.checksum, 32'd0);
    rst = 1'b0;
    @(posedge test_clk); #1;
    chk("post_rst_proc_hold", 32'(lif.proc_hold), 32'd1);
    chk("post_rst_done", 32'(lif.done), 32'd0);

    // 2: single word
    log_addr.delete(); log_data.delete();
    do_start(1);
    send_word(32'hDEADBEEF, 1'b0);
    wait_done("t2_timeout");
    chk("t2_writes", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      chk("t2_addr", 32'(log_addr[0]), 32'd0);
      chk("t2_data", log_data[0], 32'hDEADBEEF);
    end
    chk("t2_done", 32'(lif.done), 32'd1);
    chk("t2_hold", 32'(lif.proc_hold), 32'd0);
    chk("t2_checksum", lif.checksum, 32'hDEADBEEF);

    // 3: two words with gaps
    log_addr.delete(); log_data.delete();
    do_start(2);
    send_word(32'hCAFEBABE, 1'b1);
    send_word(32'h12345678, 1'b1);
    wait_done("t3_timeout");
    chk("t3_writes", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("t3_addr0", 32'(log_addr[0]), 32'd0);
      chk("t3_data0", log_data[0], 32'hCAFEBABE);
      chk("t3_addr1", 32'(log_addr[1]), 32'd1);
      chk("t3_data1", log_data[1], 32'h12345678);
    end
    chk("t3_checksum", lif.checksum, 32'hD8CAECC6);

    // 4a: zero words
    log_addr.delete(); log_data.delete();
    do_start(0);
    chk("t4a_done", 32'(lif.done), 32'd1);
    chk("t4a_hold", 32'(lif.proc_hold), 32'd0);
    chk("t4a_busy", 32'(lif.busy), 32'd0);
    repeat (3) @(posedge test_clk);
    #1;
    chk("t4a_writes", 32'(log_addr.size()), 32'd0);

    // 4b: 70 requested, clamped to 64
    log_addr.delete(); log_data.delete();
    do_start(70);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b0;
      b0 = 8'(4 * i);
      send_word({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 1'b0);
    end
    wait_done("t4b_timeout");
    chk("t4b_writes", 32'(log_addr.size()), 32'd64);
    if (log_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        logic [7:0] b0;
        b0 = 8'(4 * i);
        chk("t4b_addr", 32'(log_addr[i]), 32'(i));
        chk("t4b_data", log_data[i], {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
      end
    end
    lif.byte_valid = 1'b1;
    lif.byte_data  = 8'hAA;
    repeat (3) begin
      @(posedge test_clk); #1;
      chk("t4b_extra_ready", 32'(lif.byte_ready), 32'd0);
    end
    lif.byte_valid = 1'b0;
    chk("t4b_no_extra_writes", 32'(log_addr.size()), 32'd64);

    // 5: start while busy is ignored
    log_addr.delete(); log_data.delete();
    do_start(3);
    send_word(32'h01020304, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(7);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'hA5A55A5A, 1'b0);
    wait_done("t5_timeout");
    chk("t5_writes", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t5_addr", 32'(log_addr[i]), 32'(i));
      chk("t5_data1", log_data[1], 32'h44332211);
    end

    // 6: reset mid-word, then a fresh load
    log_addr.delete(); log_data.delete();
    do_start(2);
    send_word(32'h0BADF00D, 1'b0);
    send_byte(8'hEE, 0);
    send_byte(8'hFF, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_w_en", 32'(lif.w_en), 32'd0);
    chk("t6_rst_ready", 32'(lif.byte_ready), 32'd0);
    chk("t6_rst_busy", 32'(lif.busy), 32'd0);
    chk("t6_rst_hold", 32'(lif.proc_hold), 32'd1);
    chk("t6_rst_checksum", lif.checksum, 32'd0);
    @(posedge test_clk); #1;
    rst = 1'b0;
    @(posedge test_clk); #1;
    log_addr.delete(); log_data.delete();
    do_start(1);
    send_word(32'h44332211, 1'b0);
    wait_done("t6_timeout");
    chk("t6_writes", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      chk("t6_addr", 32'(log_addr[0]), 32'd0);
      chk("t6_data", log_data[0], 32'h44332211);
    end
    chk("t6_hold", 32'(lif.proc_hold), 32'd0);
    chk("t6_checksum", lif.checksum, 32'h44332211);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
